// File: rtl/blink_meter.sv
// blink_meter: synchronises and debounces an asynchronous blink input, measures the
// clock count between accepted edges and flags an input that has stopped toggling.
module blink_meter #(
    parameter int CNT_W      = 26,
    parameter int TIMEOUT    = 60000000,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             level,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             stalled,
    output logic [15:0]      edge_count
);

    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

    state_t           state;
    logic             sync_p0;
    logic             sync_p1;
    logic [DEB_W-1:0] deb_cnt;
    logic [CNT_W-1:0] timer;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == TIMER_LAST) ? v : v + CNT_W'(1);
    endfunction

    // The DEB_CYCLES-th consecutive mismatching cycle is the accepted edge.
    assign accept = (sync_p1 != level) && (deb_cnt == DEB_LAST);

    // Stage p0/p1: two-flop synchroniser on the raw pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= sig_in;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: glitch filter producing the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else if (sync_p1 == level) begin
            deb_cnt <= '0;
        end else if (accept) begin
            deb_cnt <= '0;
            level   <= ~level;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (accept) begin
            timer <= '0;
        end else begin
            timer <= sat_inc(timer);
        end
    end

    // An edge in the same cycle as the timeout wins and reports TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            half_period  <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            edge_count   <= '0;
        end else begin
            period_valid <= 1'b0;
            if (accept) begin
                edge_count <= edge_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        half_period  <= timer + CNT_W'(1);
                        period_valid <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        state   <= STALL;
                        stalled <= 1'b1;
                    end
                end
                STALL: begin
                    if (accept) begin
                        state   <= MEASURE;
                        stalled <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_meter.sv
// Bench for blink_meter: directed phases plus random toggling, checked every cycle
// against an interval-level model built from the scheduled accepted-edge times.
module tb_blink_meter;

    localparam int CNT_W   = 26;
    localparam int TIMEOUT = 1000;
    localparam int DEB     = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_STALL = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             level;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             stalled;
    logic [15:0]      edge_count;

    logic             w_rst_n;
    logic             w_sig;
    logic             w_level;
    logic [CNT_W-1:0] w_half;
    logic             w_pv;
    logic             w_stalled;
    logic [15:0]      w_edge;

    int total = 0;
    int bad   = 0;

    int unsigned cyc = 0;
    int unsigned acc_q[$];
    bit          m_level;
    bit          chk_en = 1'b0;
    bit          e_level;
    logic [15:0] e_cnt;
    logic [CNT_W-1:0] e_half;
    bit          e_pv;
    bit          e_stall;
    int          e_state;
    int unsigned last_acc;
    int          pv_cnt = 0;
    int          stall_cnt = 0;

    blink_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEB_CYCLES(DEB)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .level(level),
        .half_period(half_period), .period_valid(period_valid),
        .stalled(stalled), .edge_count(edge_count)
    );

    blink_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEB_CYCLES(1)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .sig_in(w_sig), .level(w_level),
        .half_period(w_half), .period_valid(w_pv),
        .stalled(w_stalled), .edge_count(w_edge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle the pin and hold for len cycles; a long-enough level change is
    // accepted DEB+2 posedges after the negedge on which it is driven.
    task automatic tog(input int len);
        sig_in = ~sig_in;
        if (sig_in != m_level && len >= DEB) begin
            acc_q.push_back(cyc + DEB + 2);
            m_level = sig_in;
        end
        tick(len);
    endtask

    task automatic model_reset();
        acc_q.delete();
        m_level  = 1'b0;
        e_level  = 1'b0;
        e_cnt    = '0;
        e_half   = '0;
        e_pv     = 1'b0;
        e_stall  = 1'b0;
        e_state  = M_IDLE;
        last_acc = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            e_pv = 1'b0;
            if (acc_q.size() > 0 && acc_q[0] == cyc) begin
                void'(acc_q.pop_front());
                e_level = ~e_level;
                e_cnt   = e_cnt + 16'd1;
                if (e_state == M_ARMED) begin
                    e_pv   = 1'b1;
                    e_half = CNT_W'(cyc - last_acc);
                end
                e_state  = M_ARMED;
                e_stall  = 1'b0;
                last_acc = cyc;
            end else if (e_state == M_ARMED && cyc - last_acc == TIMEOUT) begin
                e_state = M_STALL;
                e_stall = 1'b1;
            end
            if (period_valid === 1'b1) pv_cnt++;
            if (stalled === 1'b1) stall_cnt++;
            check("cycle", 64'({level, edge_count, period_valid, stalled, half_period}),
                  64'({e_level, e_cnt, e_pv, e_stall, e_half}));
        end
    end

    initial begin
        int snap_pv;
        int snap_st;
        int len;
        rst_n   = 1'b0;
        sig_in  = 1'b0;
        w_rst_n = 1'b0;
        w_sig   = 1'b0;
        model_reset();
        fork
            begin
                tick(3);
                w_rst_n = 1'b1;
                tick(2);
                repeat (65535) begin
                    w_sig = ~w_sig;
                    tick(1);
                end
                tick(6);
                check("wrap_ffff", 64'(w_edge), 64'h0000_0000_0000_ffff);
                repeat (2) begin
                    w_sig = ~w_sig;
                    tick(1);
                end
                tick(6);
                check("wrap_edges", 64'(w_edge), 64'd1);
                check("wrap_level", 64'(w_level), 64'd1);
                check("wrap_half", 64'(w_half), 64'd1);
                check("wrap_stall", 64'(w_stalled), 64'd0);
            end
            begin
                // reset with the pin toggling
                repeat (6) tog(1);
                check("reset_outputs", 64'({level, edge_count, period_valid, stalled, half_period}), 64'd0);
                sig_in = 1'b0;
                tick(3);
                model_reset();
                rst_n  = 1'b1;
                chk_en = 1'b1;
                tick(1500);
                check("idle_no_stall", 64'(stalled), 64'd0);
                check("idle_edges", 64'(edge_count), 64'd0);

                // square wave, 100-cycle half period
                tog(5);
                check("latency_before", 64'(level), 64'd0);
                tick(1);
                check("latency_after", 64'(level), 64'd1);
                check("first_edge_cnt", 64'(edge_count), 64'd1);
                check("first_edge_nopv", 64'(pv_cnt), 64'd0);
                tick(94);
                repeat (5) tog(100);
                check("sq_edges", 64'(edge_count), 64'd6);
                check("sq_half", 64'(half_period), 64'd100);
                check("sq_pv_count", 64'(pv_cnt), 64'd5);

                // glitches
                tog(3);
                tog(30);
                check("glitch3_edges", 64'(edge_count), 64'd6);
                check("glitch3_pv", 64'(pv_cnt), 64'd5);
                tog(4);
                tog(30);
                check("pulse4_edges", 64'(edge_count), 64'd8);
                check("pulse4_half", 64'(half_period), 64'd4);
                check("pulse4_level", 64'(level), 64'd0);

                // stall and recovery
                tog(4);
                tog(1005);
                check("stall_before", 64'(stalled), 64'd0);
                tick(1);
                check("stall_at", 64'(stalled), 64'd1);
                check("stall_half", 64'(half_period), 64'd4);
                snap_pv = pv_cnt;
                tick(200);
                tog(250);
                check("recover_stall", 64'(stalled), 64'd0);
                check("recover_nopv", 64'(pv_cnt), 64'(snap_pv));
                tog(250);
                check("recover_half", 64'(half_period), 64'd250);
                check("recover_pv", 64'(pv_cnt), 64'(snap_pv + 1));

                // boundary: exactly TIMEOUT, then TIMEOUT+1
                snap_st = stall_cnt;
                tog(1000);
                tog(1001);
                check("bound_half", 64'(half_period), 64'd1000);
                check("bound_nostall", 64'(stall_cnt), 64'(snap_st));
                snap_pv = pv_cnt;
                tog(50);
                check("over_stall_pulse", 64'(stall_cnt), 64'(snap_st + 1));
                check("over_nopv", 64'(pv_cnt), 64'(snap_pv));
                check("over_half", 64'(half_period), 64'd1000);

                // asynchronous reset mid-measurement
                @(posedge clk);
                #2;
                rst_n  = 1'b0;
                chk_en = 1'b0;
                #1;
                check("async_reset", 64'({level, edge_count, period_valid, stalled, half_period}), 64'd0);
                sig_in = 1'b0;
                model_reset();
                tick(3);
                rst_n  = 1'b1;
                chk_en = 1'b1;
                snap_pv = pv_cnt;
                tog(120);
                check("rearm_edges", 64'(edge_count), 64'd1);
                check("rearm_nopv", 64'(pv_cnt), 64'(snap_pv));
                tog(77);
                check("rearm_half", 64'(half_period), 64'd120);
                check("rearm_pv", 64'(pv_cnt), 64'(snap_pv + 1));

                // random toggling mixing glitches, short, long and near-timeout intervals
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 4))
                        0:       len = $urandom_range(1, 3);
                        1:       len = $urandom_range(4, 8);
                        2:       len = $urandom_range(9, 300);
                        3:       len = $urandom_range(995, 1005);
                        default: len = $urandom_range(1006, 1200);
                    endcase
                    tog(len);
                end
                tog(30);
                chk_en = 1'b0;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
